// File: rtl/invsqrt_out_fifo.sv
// Result buffer for the inverse-sqrt pipeline: restores the sign bit, queues results, tracks issue credits.
// Latency: push visible on out_valid one edge after in_ready; show-ahead output.
// Backpressure: none upstream (results dropped when full); issue_ok gates new operands by credit.
module invsqrt_out_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_issue,
    output logic          issue_ok,
    input  logic          in_ready,
    input  logic [30:0]   in_data,
    output logic          out_valid,
    output logic [31:0]   out_data,
    input  logic          out_ack,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [1:0]    err,
    input  logic          clear_err
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [30:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   inflight;
    logic          pop;
    logic          push;
    logic          drop;
    logic          issue_bad;
    logic [1:0]    err_next;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign out_valid = !empty;
    assign out_data  = out_valid ? {1'b0, mem[rd_ptr]} : 32'd0;
    assign issue_ok  = ({1'b0, count} + {1'b0, inflight}) < DEPTH_W;

    // A full buffer still accepts a result when the same edge frees a slot.
    assign pop       = out_valid && out_ack;
    assign push      = in_ready && (!full || pop);
    assign drop      = in_ready && full && !pop;
    assign issue_bad = in_issue && !issue_ok;

    always_comb begin
        err_next = clear_err ? 2'b00 : err;
        if (drop)
            err_next[0] = 1'b1;
        if (issue_bad)
            err_next[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            err      <= 2'b00;
        end else begin
            err <= err_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Over-issue saturates; a stray result with nothing in flight leaves it at zero.
            case ({in_issue, in_ready})
                2'b10:   if (inflight != DEPTH_C) inflight <= inflight + 1'b1;
                2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_invsqrt_out_fifo.sv
// Directed bench for invsqrt_out_fifo with a queue-based reference model checked every cycle.
module tb_invsqrt_out_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_issue;
    logic        issue_ok;
    logic        in_ready;
    logic [30:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ack;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic [1:0]  err;
    logic        clear_err;

    int checks   = 0;
    int failures = 0;

    invsqrt_out_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_issue  (in_issue),
        .issue_ok  (issue_ok),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err       (err),
        .clear_err (clear_err)
    );

    always #5 clk = ~clk;

    // Reference model: results held in a plain queue, credits as an integer.
    logic [30:0] mq[$];
    int          m_infl;
    logic [1:0]  m_err;

    always @(posedge clk or negedge rst_n) begin
        int  sz;
        bit  p;
        bit  ok;
        if (!rst_n) begin
            mq.delete();
            m_infl = 0;
            m_err  = 2'b00;
        end else begin
            sz = mq.size();
            p  = (sz > 0) && out_ack;
            ok = (sz + m_infl) < DEPTH;
            if (clear_err)
                m_err = 2'b00;
            if (p)
                void'(mq.pop_front());
            if (in_ready) begin
                if (sz < DEPTH || p)
                    mq.push_back(in_data);
                else
                    m_err[0] = 1'b1;
            end
            if (in_issue && !ok)
                m_err[1] = 1'b1;
            if (in_issue && !in_ready && m_infl < DEPTH)
                m_infl++;
            else if (in_ready && !in_issue && m_infl > 0)
                m_infl--;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int sz;
        sz = mq.size();
        chk("m_valid", 32'(out_valid), 32'(sz > 0));
        chk("m_data", out_data, (sz > 0) ? {1'b0, mq[0]} : 32'd0);
        chk("m_count", 32'(count), 32'(sz));
        chk("m_full", 32'(full), 32'(sz == DEPTH));
        chk("m_empty", 32'(empty), 32'(sz == 0));
        chk("m_issue_ok", 32'(issue_ok), 32'((sz + m_infl) < DEPTH));
        chk("m_err", 32'(err), 32'(m_err));
    end

    task automatic drive(input logic iss, input logic rdy, input logic [30:0] d,
                         input logic ack, input logic clr);
        in_issue  = iss;
        in_ready  = rdy;
        in_data   = d;
        out_ack   = ack;
        clear_err = clr;
        @(posedge clk);
        #1;
        in_issue  = 1'b0;
        in_ready  = 1'b0;
        in_data   = '0;
        out_ack   = 1'b0;
        clear_err = 1'b0;
    endtask

    logic [30:0] exp3 [3];
    logic [30:0] exp8 [8];

    initial begin
        rst_n = 1'b0;
        in_issue = 1'b0; in_ready = 1'b0; in_data = '0; out_ack = 1'b0; clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_issue_ok", 32'(issue_ok), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ordered push then pop.
        exp3[0] = 31'h3F800000; exp3[1] = 31'h3F000000; exp3[2] = 31'h3E800000;
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, exp3[i], 1'b0, 1'b0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_head", out_data, 32'h3F800000);
        for (int i = 0; i < 3; i++) begin
            chk("t1_pop_data", out_data, {1'b0, exp3[i]});
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_data0", out_data, 32'd0);

        // Credit exhaustion and over-issue.
        for (int i = 0; i < 7; i++)
            drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t2_ok_after7", 32'(issue_ok), 32'd1);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t2_ok_after8", 32'(issue_ok), 32'd0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t2_err_issue", 32'(err), 32'h2);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("t2_err_clear", 32'(err), 32'h0);

        // Fill, drop on full, then accept with a simultaneous pop.
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 31'(32'h100 + i), 1'b0, 1'b0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count8", 32'(count), 32'd8);
        drive(1'b0, 1'b1, 31'h1FF, 1'b0, 1'b0);
        chk("t3_drop_err", 32'(err), 32'h1);
        chk("t3_drop_count", 32'(count), 32'd8);
        drive(1'b0, 1'b1, 31'h200, 1'b1, 1'b0);
        chk("t3_acc_count", 32'(count), 32'd8);
        for (int i = 0; i < 7; i++)
            exp8[i] = 31'(32'h101 + i);
        exp8[7] = 31'h200;
        for (int i = 0; i < 8; i++) begin
            chk("t3_order", out_data, {1'b0, exp8[i]});
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        chk("t3_drained", 32'(empty), 32'd1);

        // Saturated credit count returned to zero after eight results.
        for (int i = 0; i < 7; i++)
            drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t2_sat_ok", 32'(issue_ok), 32'd1);

        // count=5, inflight=2, then asynchronous reset between edges.
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b1, 31'(32'h300 + i), 1'b0, 1'b0);
        chk("t7_count5", 32'(count), 32'd5);
        chk("t7_err_pre", 32'(err), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_valid", 32'(out_valid), 32'd0);
        chk("t7_data", out_data, 32'd0);
        chk("t7_count", 32'(count), 32'd0);
        chk("t7_empty", 32'(empty), 32'd1);
        chk("t7_full", 32'(full), 32'd0);
        chk("t7_err", 32'(err), 32'd0);
        chk("t7_issue_ok", 32'(issue_ok), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Push into empty buffer with a simultaneous ack: nothing popped.
        drive(1'b0, 1'b1, 31'h55AA, 1'b1, 1'b0);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_data", out_data, 32'h000055AA);
        chk("t4_count", 32'(count), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Streaming with ack held high, wrapping the pointers.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 31'(32'h7000 + i), 1'b1, 1'b0);
            chk("t5_count_le1", 32'(count <= 1), 32'd1);
            chk("t5_data", out_data, 32'h7000 + 32'(i));
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("t5_empty", 32'(empty), 32'd1);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/invsqrt_out_fifo.md
# invsqrt_out_fifo

Result buffer directly downstream of the inverse-square-root pipeline. It captures each 31-bit result the pipeline produces, restores the 32-bit IEEE-754 single format (sign forced to 0), and queues it for a consumer that uses a valid/ack handshake. The pipeline has no backpressure, so the block also keeps a credit count (in-flight operations plus stored results) and tells the upstream issuer when a new operand may safely enter the pipeline.

## Interface

- DEPTH, 8, number of result entries; power of two, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_issue  in  1  upstream asserts for one cycle per operand launched into the pipeline (the pipeline's valid).
- issue_ok  out  1  high when a new operand may be issued this cycle.
- in_ready  in  1  pipeline result strobe (the pipeline's ready output).
- in_data  in  31  pipeline result, exponent and mantissa only.
- out_valid  out  1  a result is presented on out_data.
- out_data  out  32  {1'b0, stored 31-bit result}; 0 when out_valid is low.
- out_ack  in  1  consumer accepts out_data; a pop occurs only when out_valid && out_ack.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err  out  2  sticky error flags. Bit0 = result dropped because the buffer was full. Bit1 = in_issue asserted while issue_ok was low.
- clear_err  in  1  synchronous clear of err; a new error event in the same cycle wins.

## Operation

- Storage: a circular buffer of DEPTH × 31 bits, write pointer wr_ptr[AW-1:0], read pointer rd_ptr[AW-1:0]. Both pointers wrap modulo DEPTH.
- Push: when in_ready = 1, write in_data at wr_ptr and increment wr_ptr, unless the buffer is full and no pop happens that cycle.
  - In that case the data is discarded, wr_ptr is unchanged, and err[0] is set.
- Pop: when out_valid && out_ack, increment rd_ptr.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - This includes the full case: the push is accepted because the pop frees a slot.
- Empty buffer with in_ready and out_ack in the same cycle: no pop occurs (out_valid is low). The entry is written and becomes visible the next cycle.
- Output is show-ahead: out_data is the entry at rd_ptr whenever count > 0. out_valid = !empty.
- Credit tracking:
  - inflight[AW:0] counts operands issued but whose results have not yet arrived.
  - On in_issue, inflight increments; on in_ready, it decrements. Both together leave it unchanged.
  - issue_ok = (count + inflight) < DEPTH, computed from registered state only (no combinational path from in_issue).
- Issue violation: in_issue while issue_ok = 0 sets err[1]. The issue is still counted in inflight, saturating at DEPTH.
- inflight never decrements below 0. An in_ready with inflight = 0 is still pushed normally.
- The err bits are sticky. They clear only on clear_err or reset.

## Timing

- Reset (asynchronous assert, synchronous release by design): wr_ptr = rd_ptr = 0, count = 0, inflight = 0, err = 0. Resulting outputs: out_valid = 0, out_data = 0, empty = 1, full = 0, issue_ok = 1.
- Reset asserted mid-operation discards all stored and in-flight bookkeeping immediately, without waiting for a clock edge.
- Push-to-valid latency: 1 cycle. If in_ready is sampled at edge N, out_valid is high after edge N.
- Pop takes effect at the edge where out_ack is sampled. The next entry, or out_valid = 0, appears after that edge.
- Throughput: one push and one pop per cycle, sustained.
- count, full, empty, issue_ok and err are all registered or derived from registers; each updates one edge after its causing event.

## Test plan

- Reset, then 3 pushes of 0x3F800000 & 0x7FFFFFFF, 0x3F000000, 0x3E800000 with out_ack = 0 → count = 3, out_data = 0x3F800000. Three acks then pop the values in order, then empty = 1 and out_data = 0.
- DEPTH = 8: issue 8 operands → issue_ok falls after the 8th. A 9th issue → err = 2'b10 and inflight saturates at 8. Then clear_err → err = 0.
- Fill to full with 8 results. A 9th in_ready with out_ack = 0 → dropped, err[0] = 1, count = 8. Repeat with out_ack = 1 in the same cycle → accepted, count stays 8, FIFO order preserved.
- Empty buffer, in_ready and out_ack in the same cycle → no pop. Next cycle out_valid = 1 with the data, count = 1.
- Stream 20 results with out_ack held high, wrapping the pointers twice → every result is delivered in order, 1-cycle latency each, count ≤ 1.
- Drop rst_n between clock edges with count = 5 and inflight = 2 → immediately all outputs return to reset values and issue_ok = 1.
